ibus_fetch_buffer: RTL and testbench
====================================

# ibus_fetch_buffer

Single-line instruction fetch buffer between the CPU's `ibus` master port and the boot/program ROM. It serves sequential instruction fetches from a one-line buffer with zero added latency on a hit. On a miss it stalls the CPU and refills the whole line from the ROM through a request/acknowledge word interface. It replaces the ad-hoc wait-state emulation on the instruction side and presents the same `ibus_stall` contract the pipeline already uses.

## Interface
Parameters:
- `ADDR_WIDTH`, 13: ROM byte-address width. Address bits at and above `ADDR_WIDTH` are ignored.
- `LINE_WORDS`, 4: words per buffer line. Must be a power of two, ≥2.
- `OFF_W`, derived as `$clog2(LINE_WORDS)`: word-offset width.

Ports:
- `clk` in 1: the single clock; everything is sampled on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ibus_address` in 32: CPU fetch byte address. Bits [1:0] are ignored.
- `ibus_read` in 1: CPU fetch request.
- `ibus_rddata` out 32: instruction word. Valid only when `ibus_read=1` and `ibus_stall=0`; driven to 0 otherwise.
- `ibus_stall` out 1: combinational; high while the fetch cannot complete.
- `inv` in 1: single-cycle pulse that invalidates the buffer.
- `mem_req` out 1: ROM word request. Registered; held high until acknowledged.
- `mem_address` out ADDR_WIDTH: ROM byte address, word-aligned. Registered; stable while `mem_req=1`.
- `mem_ack` in 1: ROM acknowledge. Valid only while `mem_req=1`; ignored otherwise.
- `mem_rddata` in 32: ROM data, sampled in the cycle where `mem_req & mem_ack`.

## Operation
- Storage: `LINE_WORDS`×32 data, tag = `ibus_address[ADDR_WIDTH-1:OFF_W+2]`, 1-bit `valid`, 1-bit `drop`.
- `hit` = `valid` & (tag == incoming tag) & `state==IDLE`.
- Outputs:
  - `ibus_stall` = `ibus_read & !hit`.
  - On a hit, `ibus_rddata` = data[`ibus_address[OFF_W+1:2]`].
- FSM states: IDLE, FILL, DONE.
  - IDLE: if `ibus_read & !hit & !inv`, latch the line base (`ibus_address` with offset and [1:0] cleared), clear the word counter, set `mem_req=1` and `mem_address` = base. Go to FILL.
  - FILL: on `mem_req & mem_ack`, write `mem_rddata` to data[counter].
    - If counter < `LINE_WORDS-1`: increment the counter and `mem_address` by 4, keep `mem_req=1`.
    - Otherwise: drop `mem_req`, load the tag from the latched base, set `valid = !drop`, go to DONE.
  - DONE: clear `drop`, go to IDLE. This gives one bubble cycle for tag compare.
- Fill order: always word 0 to `LINE_WORDS-1`, ascending; no critical-word-first; no wrap.
- The CPU holds `ibus_address` and `ibus_read` while stalled. If the address changes mid-fill anyway, the fill still completes for the latched line and the new address is re-evaluated in IDLE.
- Deasserting `ibus_read` mid-fill does not abort the fill.
- `inv`:
  - In IDLE or DONE: clears `valid` at the next edge.
  - In FILL: sets `drop`, so the completing line is written but left invalid.
  - `inv` together with a miss in IDLE: invalidate only. The miss is re-detected next cycle.
- Reset values: state=IDLE, `valid=0`, `drop=0`, counter=0, `mem_req=0`, `mem_address=0`. Data RAM is not reset.
  - While `rst=1`, `ibus_stall = ibus_read` and `ibus_rddata = 0`.
  - Reset mid-fill abandons the transaction at once: `mem_req` is 0 in the cycle after the reset edge.

## Timing
- Hit: combinational, 0 wait cycles; `ibus_stall=0` in the cycle `ibus_read` rises.
- Miss detected in cycle 0 (stall=1). `mem_req` rises at edge 1.
- With ROM ack latency `A` (ack in the A-th cycle of `mem_req` high, A≥1), the fill ends after `LINE_WORDS*A` cycles in FILL.
- DONE takes 1 cycle. The stall drops in the first IDLE cycle.
- Total miss stall = `LINE_WORDS*A + 2` cycles. For the defaults with A=1 this is 6 stalled cycles; the 7th cycle completes.
- `mem_req` deasserts at the edge after the last ack. There is no back-to-back request across lines.

## Test plan
- Cold miss: after reset, hold `ibus_read=1`, `ibus_address=0x80000000`, ROM word i = 0x1000+i, A=1. Expect stall for 6 cycles, then `ibus_rddata=0x1000`. ROM must see addresses 0x000, 0x004, 0x008, 0x00C in order.
- Sequential hits: after the cold miss, fetch 0x80000004, 0x80000008, 0x8000000C on consecutive cycles. Expect `ibus_stall=0` each cycle and data 0x1001–0x1003. Then fetching 0x80000010 misses with a 6-cycle stall and returns 0x1004.
- Slow ROM: A=3, miss at 0x80000020. Expect a 14-cycle stall and `mem_address` held stable 3 cycles per word. Separately, set the bench's ack-during-`mem_req=0` checker to fire: it must never trigger.
- Invalidate mid-fill: pulse `inv` in the second FILL cycle of a miss at 0x80000040. The fill completes, then the same address misses again and performs a full second refill, for 12 stalled cycles total before data is returned.
- Reset mid-fill: assert `rst` during word 2 of a fill. Expect `mem_req=0` the next cycle. After release, a fetch of the same address is a full miss and returns correct data.
- Tag alias: fill 0x00000000, then fetch 0x00002000 (same index, bit 13 ignored). Expect a hit returning the same word. Fetch 0x00001000: expect a miss.

Source files
------------

// File: rtl/ibus_fetch_buffer_if.sv
// ---------------------------------------------------------------------------
// ibus_fetch_buffer_if
// Bundles the CPU instruction-fetch port and the ROM word-request port of
// the fetch buffer.
//   ibus_address / ibus_read     : CPU fetch byte address and request
//   ibus_rddata  / ibus_stall    : instruction word and stall back to the CPU
//   inv                          : single-cycle buffer invalidate pulse
//   mem_req / mem_address        : ROM word request and word-aligned address
//   mem_ack / mem_rddata         : ROM acknowledge and returned word
// Modport slave is the fetch buffer's view; master is the environment's
// view (CPU + ROM).
// ---------------------------------------------------------------------------
interface ibus_fetch_buffer_if #(
  parameter int ADDR_WIDTH = 13
) ();
  logic [31:0]           ibus_address;
  logic                  ibus_read;
  logic [31:0]           ibus_rddata;
  logic                  ibus_stall;
  logic                  inv;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_ack;
  logic [31:0]           mem_rddata;

  modport slave (
    input  ibus_address, ibus_read, inv, mem_ack, mem_rddata,
    output ibus_rddata, ibus_stall, mem_req, mem_address
  );

  modport master (
    output ibus_address, ibus_read, inv, mem_ack, mem_rddata,
    input  ibus_rddata, ibus_stall, mem_req, mem_address
  );
endinterface

// File: rtl/ibus_fetch_buffer.sv
// ---------------------------------------------------------------------------
// ibus_fetch_buffer
// One-line instruction fetch buffer between the CPU ibus port and the
// boot/program ROM. Hits return data combinationally with no wait state;
// a miss stalls the CPU and refills the whole line, word 0 first, through
// a request/acknowledge word interface.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : ibus_fetch_buffer_if.slave (CPU fetch port + ROM word port)
// ---------------------------------------------------------------------------
module ibus_fetch_buffer #(
  parameter int ADDR_WIDTH = 13,
  parameter int LINE_WORDS = 4,
  parameter int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  ibus_fetch_buffer_if.slave  bus
);

  localparam int TAG_W = ADDR_WIDTH - OFF_W - 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  logic [1:0]            r_state;
  logic                  r_valid;
  logic                  r_drop;
  logic [OFF_W-1:0]      r_cnt;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [TAG_W-1:0]      r_tag;
  logic [TAG_W-1:0]      r_fill_tag;
  logic [31:0]           r_data [LINE_WORDS];

  logic [TAG_W-1:0]      w_tag;
  logic [OFF_W-1:0]      w_off;
  logic                  w_hit;
  logic                  w_ack;
  logic                  w_last;
  logic                  w_unused_addr;

  assign w_tag  = bus.ibus_address[ADDR_WIDTH-1:OFF_W+2];
  assign w_off  = bus.ibus_address[OFF_W+1:2];
  // Gating with rst makes the CPU see stall=read and data=0 during reset.
  assign w_hit  = !rst && r_valid && (r_tag == w_tag) && (r_state == ST_IDLE);
  assign w_ack  = (r_state == ST_FILL) && r_mem_req && bus.mem_ack;
  assign w_last = (r_cnt == LAST_WORD);

  // Address bits above the ROM window and the byte offset play no part.
  assign w_unused_addr = ^{bus.ibus_address[31:ADDR_WIDTH], bus.ibus_address[1:0]};

  assign bus.ibus_stall  = bus.ibus_read & ~w_hit;
  assign bus.ibus_rddata = (bus.ibus_read && w_hit) ? r_data[w_off] : 32'h0000_0000;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_address = r_mem_address;

  // Control FSM: miss detection, line refill sequencing and invalidation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_valid       <= 1'b0;
      r_drop        <= 1'b0;
      r_cnt         <= '0;
      r_mem_req     <= 1'b0;
      r_mem_address <= '0;
      r_tag         <= '0;
      r_fill_tag    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.inv) begin
            // Invalidate wins over a simultaneous miss; the miss is seen again next cycle.
            r_valid <= 1'b0;
          end else if (bus.ibus_read && !w_hit) begin
            r_fill_tag    <= w_tag;
            r_cnt         <= '0;
            r_mem_req     <= 1'b1;
            r_mem_address <= {w_tag, {(OFF_W + 2){1'b0}}};
            r_state       <= ST_FILL;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (bus.inv) begin
            r_drop <= 1'b1;
          end else begin
            r_drop <= r_drop;
          end
          if (w_ack) begin
            if (!w_last) begin
              r_cnt         <= r_cnt + OFF_W'(1);
              r_mem_address <= r_mem_address + ADDR_WIDTH'(4);
            end else begin
              r_mem_req <= 1'b0;
              r_tag     <= r_fill_tag;
              // An invalidate landing on the last ack also leaves the line invalid.
              r_valid   <= !(r_drop || bus.inv);
              r_state   <= ST_DONE;
            end
          end else begin
            r_state <= ST_FILL;
          end
        end
        ST_DONE: begin
          // Bubble cycle so the freshly loaded tag is compared from a register.
          r_drop  <= 1'b0;
          r_state <= ST_IDLE;
          if (bus.inv) begin
            r_valid <= 1'b0;
          end else begin
            r_valid <= r_valid;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_valid   <= 1'b0;
          r_drop    <= 1'b0;
        end
      endcase
    end
  end

  // Line data storage; written on each accepted ROM word, intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && w_ack) begin
      r_data[r_cnt] <= bus.mem_rddata;
    end
  end

endmodule

// File: tb/tb_ibus_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_ibus_fetch_buffer
// Directed and randomized fetches against ibus_fetch_buffer. A ROM model
// with configurable ack latency answers word requests; a line-level model
// predicts hit/miss, stall length and returned data.
// ---------------------------------------------------------------------------
module tb_ibus_fetch_buffer;

  localparam int LW = 4;

  logic clk;
  logic rst;

  ibus_fetch_buffer_if #(.ADDR_WIDTH(13)) bus ();

  ibus_fetch_buffer #(
    .ADDR_WIDTH(13),
    .LINE_WORDS(LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          rom_lat = 1;
  int          rom_wait = 0;
  int          spurious = 0;
  logic [12:0] rom_hold;
  logic [12:0] mem_log[$];
  logic        model_valid = 1'b0;
  logic [8:0]  model_line = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word i of the 8 KiB window holds 0x1000 + i.
  function automatic logic [31:0] rom_word(input logic [12:0] a);
    return 32'h0000_1000 + 32'(a[12:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ROM responder: ack in the rom_lat-th cycle of each word request.
  always @(negedge clk) begin
    if (rst || bus.mem_req !== 1'b1) begin
      rom_wait       = 0;
      bus.mem_ack    = 1'b0;
      bus.mem_rddata = 32'h0;
    end else begin
      if (bus.mem_ack === 1'b1 || rom_wait == 0) begin
        rom_wait = 1;
        rom_hold = bus.mem_address;
      end else begin
        rom_wait++;
        chk("mem_addr_stable", 32'(bus.mem_address), 32'(rom_hold));
      end
      bus.mem_ack    = (rom_wait >= rom_lat);
      bus.mem_rddata = rom_word(bus.mem_address);
      if (bus.mem_ack) mem_log.push_back(bus.mem_address);
    end
  end

  // Flags any acknowledge presented while no request is outstanding.
  always @(posedge clk) begin
    if (bus.mem_ack === 1'b1 && bus.mem_req !== 1'b1) spurious++;
  end

  // One fetch: present address, count stalled cycles, check returned word.
  task automatic do_fetch(input logic [31:0] a, input int lat, input int exp_n,
                          input int inv_cycle, input string tag);
    int n;
    @(negedge clk);
    rom_lat          = lat;
    bus.ibus_address = a;
    bus.ibus_read    = 1'b1;
    bus.inv          = (inv_cycle == 0);
    #1;
    n = 0;
    while (bus.ibus_stall === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      bus.inv = (n == inv_cycle);
      #1;
    end
    bus.inv = 1'b0;
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_data"}, bus.ibus_rddata, rom_word(a[12:0]));
    model_valid = 1'b1;
    model_line  = a[12:4];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] r;
    logic [8:0]  line;
    int          lat;
    int          exp_n;

    rst              = 1'b1;
    bus.ibus_read    = 1'b1;
    bus.ibus_address = 32'h8000_0000;
    bus.inv          = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(bus.ibus_stall), 32'h1);
    chk("rst_rddata", bus.ibus_rddata, 32'h0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_mem_address", 32'(bus.mem_address), 32'h0);
    @(negedge clk);
    rst           = 1'b0;
    bus.ibus_read = 1'b0;
    #1;
    chk("idle_stall", 32'(bus.ibus_stall), 32'h0);
    chk("idle_rddata", bus.ibus_rddata, 32'h0);

    // Cold miss and ROM address order
    mem_log.delete();
    do_fetch(32'h8000_0000, 1, 6, -1, "cold");
    chk("cold_req_count", 32'(mem_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cold_req_addr", (i < mem_log.size()) ? 32'(mem_log[i]) : 32'hFFFF_FFFF, 32'(i * 4));
    end

    // Sequential hits, then next line misses
    do_fetch(32'h8000_0004, 1, 0, -1, "hit1");
    do_fetch(32'h8000_0008, 1, 0, -1, "hit2");
    do_fetch(32'h8000_000C, 1, 0, -1, "hit3");
    do_fetch(32'h8000_0010, 1, 6, -1, "next_line");

    // Slow ROM: 3-cycle ack latency
    do_fetch(32'h8000_0020, 3, 14, -1, "slow");

    // Invalidate in the second fill cycle forces a second refill
    do_fetch(32'h8000_0040, 1, 12, 2, "inv_fill");

    // Reset during word 2 of a fill
    @(negedge clk);
    rom_lat          = 1;
    bus.ibus_address = 32'h8000_0080;
    bus.ibus_read    = 1'b1;
    #1;
    chk("rstfill_miss_stall", 32'(bus.ibus_stall), 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rstfill_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rstfill_stall", 32'(bus.ibus_stall), 32'h1);
    chk("rstfill_rddata", bus.ibus_rddata, 32'h0);
    rst           = 1'b0;
    bus.ibus_read = 1'b0;
    model_valid   = 1'b0;
    do_fetch(32'h8000_0080, 1, 6, -1, "after_rst");

    // Tag alias: bit 13 ignored, bit 12 significant
    do_fetch(32'h0000_0000, 1, 6, -1, "alias_fill");
    do_fetch(32'h0000_2000, 1, 0, -1, "alias_hit");
    do_fetch(32'h0000_1000, 2, 10, -1, "alias_miss");

    // Randomized fetches and idle/invalidate cycles against the line model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 2) begin
        @(negedge clk);
        bus.ibus_read    = 1'b0;
        bus.ibus_address = $urandom();
        bus.inv          = 1'($urandom_range(0, 1));
        #1;
        chk("rnd_idle_stall", 32'(bus.ibus_stall), 32'h0);
        chk("rnd_idle_rddata", bus.ibus_rddata, 32'h0);
        if (bus.inv) model_valid = 1'b0;
      end else begin
        r    = $urandom();
        line = ($urandom_range(0, 1) == 1) ? model_line : 9'($urandom_range(0, 511));
        a    = (r & 32'hFFFF_E003) | (32'(line) << 4) | (32'($urandom_range(0, 3)) << 2);
        lat  = $urandom_range(1, 3);
        exp_n = (model_valid && model_line == a[12:4]) ? 0 : LW * lat + 2;
        do_fetch(a, lat, exp_n, -1, "rnd");
      end
    end

    @(negedge clk);
    bus.ibus_read = 1'b0;
    bus.inv       = 1'b0;
    #1;
    chk("ack_without_req", 32'(spurious), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
